// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU register window with TX/RX byte FIFOs and handshake glue for the pipeline UART core
module uart_mmio_ctrl #(
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 8,
  parameter logic [15:0] BAUD_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wen,
  input  logic [31:0] bus_wdata,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        uart_we,
  output logic [7:0]  uart_data,
  input  logic        uart_busy,
  output logic [15:0] uart_baud_max,
  input  logic        uart_read_ready,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_negate_read_ready,
  output logic        irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} tx_state_t;
  tx_state_t state, state_nx;
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic [RAW:0] rx_wp, rx_rp;
  logic [1:0] tmo;
  logic tx_ovf, rx_ovf, rx_ack;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
  logic sel_tx, sel_rx, sel_st, sel_bd;
  logic tx_push_req, tx_push, tx_pop, rx_cap, rx_push, rx_pop;
  logic [6:0] status;
  logic [31:0] rdata_nx;
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};
  assign sel_tx = bus_addr[3:2] == 2'd0;
  assign sel_rx = bus_addr[3:2] == 2'd1;
  assign sel_st = bus_addr[3:2] == 2'd2;
  assign sel_bd = bus_addr[3:2] == 2'd3;
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign tx_pop      = state == IDLE && !tx_empty && !uart_busy;
  assign tx_push_req = bus_wen && sel_tx;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_cap  = uart_read_ready && !rx_ack;
  assign rx_pop  = bus_ren && sel_rx && !rx_empty;
  assign rx_push = rx_cap && (!rx_full || rx_pop);
  assign tx_idle = tx_empty && state == IDLE && !uart_busy;
  assign status  = {tx_idle, rx_ovf, tx_ovf, rx_full, rx_empty, tx_empty, tx_full};
  assign uart_we = state == ISSUE;
  assign uart_negate_read_ready = rx_ack;
  assign irq = !rx_empty || tx_ovf || rx_ovf;
  always_comb begin
    rdata_nx = sel_st ? {25'd0, status} :
               sel_bd ? {16'd0, uart_baud_max} :
               (sel_rx && !rx_empty) ? {23'd0, 1'b1, rx_mem[rx_rp[RAW-1:0]]} : 32'd0;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = tx_pop ? ISSUE : IDLE;
      ISSUE:      state_nx = WAIT_START;
      WAIT_START: state_nx = uart_busy ? WAIT_DONE : (tmo == 2'd3) ? ISSUE : WAIT_START;
      WAIT_DONE:  state_nx = uart_busy ? WAIT_DONE : IDLE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo           <= 2'd0;
      tx_wp         <= '0;
      tx_rp         <= '0;
      rx_wp         <= '0;
      rx_rp         <= '0;
      tx_ovf        <= 1'b0;
      rx_ovf        <= 1'b0;
      rx_ack        <= 1'b0;
      uart_data     <= 8'd0;
      bus_rdata     <= 32'd0;
      uart_baud_max <= BAUD_RESET;
    end else begin
      state <= state_nx;
      tmo   <= (state == WAIT_START) ? tmo + 2'd1 : 2'd0;
      if (tx_pop) begin
        uart_data <= tx_mem[tx_rp[TAW-1:0]];
        tx_rp     <= tx_rp + 1'b1;
      end
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      tx_ovf <= (tx_ovf && !(bus_wen && sel_st && bus_wdata[4])) || (tx_push_req && !tx_push);
      rx_ovf <= (rx_ovf && !(bus_wen && sel_st && bus_wdata[5])) || (rx_cap && !rx_push);
      // a new byte is only taken once read_ready has been seen low again
      rx_ack <= uart_read_ready;
      if (bus_wen && sel_bd) uart_baud_max <= (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];
      if (bus_ren) bus_rdata <= rdata_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= bus_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= uart_rx_data;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Bus-side controller that sits directly upstream and downstream of the pipeline UART core.
- Accepts CPU register writes and buffers TX bytes in a FIFO, then drains them into the core with the core's write_enable/busy handshake.
- Captures each received byte from the core into an RX FIFO and acknowledges it with negate_read_ready.
- Exposes status, sticky error flags and the baud divisor to the CPU through a 4-register memory-mapped window.

Parameters:
- TX_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of two, ≥2)
- BAUD_RESET, 16'd434, reset value of the baud divisor register

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- bus_addr  in  4  byte address; only [3:2] decoded
- bus_wen  in  1  write strobe, one cycle per access
- bus_wdata  in  32  write data
- bus_ren  in  1  read strobe, one cycle per access
- bus_rdata  out  32  read data, valid the cycle after bus_ren
- uart_we  out  1  to core write_enable
- uart_data  out  8  to core data; held stable while a byte is in flight
- uart_busy  in  1  from core busy
- uart_baud_max  out  16  to core baud_max
- uart_read_ready  in  1  from core read_ready (level)
- uart_rx_data  in  8  from core rx_data
- uart_negate_read_ready  out  1  to core negate_read_ready
- irq  out  1  level: (rx not empty) OR (tx_overflow) OR (rx_overflow)

Behaviour:

Reset:
- All outputs 0 except uart_baud_max = BAUD_RESET.
- FIFOs empty, sticky flags 0, TX FSM in IDLE.

Register map (offset, access):
- 0x0 TXDATA, write-only.
  - Push wdata[7:0] when TX FIFO is not full.
  - When full: drop the byte and set tx_overflow.
  - Reads return 0.
- 0x4 RXDATA, read-only.
  - rdata = {23'b0, valid, byte}.
  - When not empty: valid=1 and the head entry is popped.
  - When empty: returns 0 and nothing is popped.
- 0x8 STATUS, read/write-1-to-clear.
  - Bit fields: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 tx_overflow, bit5 rx_overflow, bit6 tx_idle (FIFO empty AND FSM in IDLE AND !uart_busy).
  - Writing 1 to bit4 or bit5 clears that flag; other bits ignore writes.
- 0xC BAUD, read/write.
  - [15:0] drives uart_baud_max; upper bits read 0.
  - Writing 0 is stored as 1.

Bus timing:
- bus_rdata is registered: value reflects state at the bus_ren cycle and holds until the next bus_ren.
- bus_wen and bus_ren in the same cycle: write takes effect, read returns pre-write state.

TX drain FSM:
- IDLE: if FIFO not empty and !uart_busy → pop head into the uart_data register; go to ISSUE.
- ISSUE: uart_we=1 for exactly this one cycle → WAIT_START.
- WAIT_START: wait for uart_busy=1 → WAIT_DONE.
  - Timeout after 4 cycles without busy → back to ISSUE to re-strobe the same byte.
- WAIT_DONE: wait for uart_busy=0 → IDLE.
- uart_data changes only on the IDLE pop.
- Minimum latency from TXDATA write (empty FIFO, idle core) to uart_we: 2 cycles.
- A same-cycle bus push and FSM pop on a full FIFO is legal: the push is accepted.

RX capture:
- Internal rx_ack register.
- When uart_read_ready=1 and rx_ack=0:
  - Push uart_rx_data, or set rx_overflow and drop the byte if the FIFO is full.
  - Set rx_ack.
- uart_negate_read_ready = rx_ack.
- rx_ack clears the first cycle uart_read_ready is seen 0.
- Exactly one push per read_ready assertion.
- A same-cycle RXDATA pop and capture push on a full FIFO is accepted, with no overflow.

FIFO implementation:
- Circular buffers with (log2 depth + 1)-bit pointers.
- Full = MSBs differ and low bits equal; wrap-around is natural.

Reset mid-transfer:
- FSM and FIFOs clear immediately and uart_we drops.
- The byte already in the core completes on the line. This is acceptable.

Test Plan:
- Reset: check rdata 0, STATUS=0x46 (tx_empty, rx_empty, tx_idle), BAUD reads 434, irq=0.
- Write 0x41,0x42 to TXDATA with a core model asserting busy 1 cycle after uart_we for 20 cycles:
  - uart_we pulses twice; uart_data is 0x41 then 0x42.
  - Second pulse only after busy falls.
  - tx_idle returns to 1.
- Write 9 bytes with the core held busy:
  - 8 accepted, tx_full=1, tx_overflow=1, irq=1.
  - Write STATUS 0x10 → tx_overflow=0.
- Hold uart_read_ready=1 with rx_data=0x5A until negate is seen:
  - Exactly one push; read RXDATA → 0x15A, then read RXDATA → 0x000.
- Nine RX bytes with no reads:
  - rx_full=1, rx_overflow=1.
  - The ninth byte is dropped; the first 8 read back in order.
- Core model never asserts busy after uart_we:
  - uart_we re-pulses every 5 cycles with uart_data unchanged.
  - Assert rst mid-sequence → all outputs reset next cycle.
